// File: rtl/hazard_scoreboard_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_unit_if
// Brief    : Pipeline-stage hazard information and interlock/forwarding controls.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_unit_if #(
    parameter int REG_ADDR_WIDTH = 5
);
    logic [REG_ADDR_WIDTH-1:0] RsD;
    logic [REG_ADDR_WIDTH-1:0] RtD;
    logic                      BranchD;
    logic                      UsesHiLoD;
    logic                      MultiCycleD;
    logic [REG_ADDR_WIDTH-1:0] RsE;
    logic [REG_ADDR_WIDTH-1:0] RtE;
    logic [REG_ADDR_WIDTH-1:0] WriteRegE;
    logic                      RegWriteE;
    logic                      MemtoRegE;
    logic                      MultiCycleE;
    logic [REG_ADDR_WIDTH-1:0] WriteRegM;
    logic                      RegWriteM;
    logic                      MemtoRegM;
    logic [REG_ADDR_WIDTH-1:0] WriteRegW;
    logic                      RegWriteW;

    logic                      StallF;
    logic                      StallD;
    logic                      FlushE;
    logic                      ForwardAD;
    logic                      ForwardBD;
    logic [1:0]                ForwardAE;
    logic [1:0]                ForwardBE;
    logic                      McBusy;
    logic                      McDone;
    logic                      McOverlap;

    // Pipeline side: supplies stage information, consumes controls.
    modport master (
        output RsD, RtD, BranchD, UsesHiLoD, MultiCycleD,
        output RsE, RtE, WriteRegE, RegWriteE, MemtoRegE, MultiCycleE,
        output WriteRegM, RegWriteM, MemtoRegM, WriteRegW, RegWriteW,
        input  StallF, StallD, FlushE, ForwardAD, ForwardBD,
        input  ForwardAE, ForwardBE, McBusy, McDone, McOverlap
    );

    // Hazard unit side.
    modport slave (
        input  RsD, RtD, BranchD, UsesHiLoD, MultiCycleD,
        input  RsE, RtE, WriteRegE, RegWriteE, MemtoRegE, MultiCycleE,
        input  WriteRegM, RegWriteM, MemtoRegM, WriteRegW, RegWriteW,
        output StallF, StallD, FlushE, ForwardAD, ForwardBD,
        output ForwardAE, ForwardBE, McBusy, McDone, McOverlap
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_unit
// Brief    : 5-stage MIPS hazard/forwarding unit with a one-entry HI/LO
//            multi-cycle scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MC_LATENCY     = 4,
    parameter int CNT_WIDTH      = 3
) (
    input  wire logic                CLK,
    input  wire logic                RST,
    hazard_scoreboard_unit_if.slave  hz
);

    localparam logic [CNT_WIDTH-1:0] c_mc_load = CNT_WIDTH'(MC_LATENCY - 1);

    logic                 r_mc_busy;
    logic [CNT_WIDTH-1:0] r_mc_cnt;
    logic                 r_mc_overlap;

    logic [1:0] w_fwd_ae;
    logic [1:0] w_fwd_be;
    logic       w_fwd_ad;
    logic       w_fwd_bd;
    logic       w_lwstall;
    logic       w_branchstall;
    logic       w_mcstall;
    logic       w_mc_done;
    logic       w_stall;

    // Memory-stage result is newer than Writeback, so it wins.
    always_comb begin
        w_fwd_ae = 2'b00;
        if (hz.RsE != '0 && hz.RegWriteM && hz.RsE == hz.WriteRegM)
            w_fwd_ae = 2'b10;
        else if (hz.RsE != '0 && hz.RegWriteW && hz.RsE == hz.WriteRegW)
            w_fwd_ae = 2'b01;

        w_fwd_be = 2'b00;
        if (hz.RtE != '0 && hz.RegWriteM && hz.RtE == hz.WriteRegM)
            w_fwd_be = 2'b10;
        else if (hz.RtE != '0 && hz.RegWriteW && hz.RtE == hz.WriteRegW)
            w_fwd_be = 2'b01;
    end

    assign w_fwd_ad = (hz.RsD != '0) && hz.RegWriteM && (hz.RsD == hz.WriteRegM);
    assign w_fwd_bd = (hz.RtD != '0) && hz.RegWriteM && (hz.RtD == hz.WriteRegM);

    // Register 0 is deliberately not excluded from the load-use compare.
    assign w_lwstall = hz.MemtoRegE && ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));

    assign w_branchstall = hz.BranchD &&
        ((hz.RegWriteE && ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD))) ||
         (hz.MemtoRegM && ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD))));

    // Still stalls during the done cycle: the HI/LO write lands at its end.
    assign w_mcstall = r_mc_busy && (hz.UsesHiLoD || hz.MultiCycleD);
    assign w_mc_done = r_mc_busy && (r_mc_cnt == '0);
    assign w_stall   = w_lwstall | w_branchstall | w_mcstall;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mc_busy    <= 1'b0;
            r_mc_cnt     <= '0;
            r_mc_overlap <= 1'b0;
        end else if (!r_mc_busy) begin
            if (hz.MultiCycleE) begin
                r_mc_busy <= 1'b1;
                r_mc_cnt  <= c_mc_load;
            end
        end else begin
            // A second issue while busy is dropped and only flagged.
            if (hz.MultiCycleE)
                r_mc_overlap <= 1'b1;
            if (r_mc_cnt == '0)
                r_mc_busy <= 1'b0;
            else
                r_mc_cnt <= r_mc_cnt - 1'b1;
        end
    end

    assign hz.StallF    = w_stall;
    assign hz.StallD    = w_stall;
    assign hz.FlushE    = w_stall;
    assign hz.ForwardAD = w_fwd_ad;
    assign hz.ForwardBD = w_fwd_bd;
    assign hz.ForwardAE = w_fwd_ae;
    assign hz.ForwardBE = w_fwd_be;
    assign hz.McBusy    = r_mc_busy;
    assign hz.McDone    = w_mc_done;
    assign hz.McOverlap = r_mc_overlap;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard_unit
// Brief    : Directed self-checking bench for hazard_scoreboard_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard_unit;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    hazard_scoreboard_unit_if #(.REG_ADDR_WIDTH(5)) hz  ();
    hazard_scoreboard_unit_if #(.REG_ADDR_WIDTH(5)) hz1 ();

    hazard_scoreboard_unit #(.REG_ADDR_WIDTH(5), .MC_LATENCY(4), .CNT_WIDTH(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .hz  (hz)
    );

    hazard_scoreboard_unit #(.REG_ADDR_WIDTH(5), .MC_LATENCY(1), .CNT_WIDTH(3)) dut1 (
        .CLK (CLK),
        .RST (RST),
        .hz  (hz1)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        hz.RsD = '0; hz.RtD = '0; hz.BranchD = 1'b0; hz.UsesHiLoD = 1'b0; hz.MultiCycleD = 1'b0;
        hz.RsE = '0; hz.RtE = '0; hz.WriteRegE = '0; hz.RegWriteE = 1'b0; hz.MemtoRegE = 1'b0;
        hz.MultiCycleE = 1'b0; hz.WriteRegM = '0; hz.RegWriteM = 1'b0; hz.MemtoRegM = 1'b0;
        hz.WriteRegW = '0; hz.RegWriteW = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        hz.MultiCycleE = 1'b1;
        hz.UsesHiLoD   = 1'b1;
        RST = 1'b1;
        step();
        step();
        n_checks++;
        if (hz.McBusy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b expected 0", hz.McBusy);
        end
        n_checks++;
        if ({hz.McDone, hz.McOverlap} !== 2'b00) begin
            n_fail++; $display("FAIL reset_done_ovl got %b expected 00", {hz.McDone, hz.McOverlap});
        end
        n_checks++;
        if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b000) begin
            n_fail++; $display("FAIL reset_stall got %b expected 000", {hz.StallF, hz.StallD, hz.FlushE});
        end
        n_checks++;
        if (dut.r_mc_cnt !== 3'd0) begin
            n_fail++; $display("FAIL reset_cnt got %0d expected 0", dut.r_mc_cnt);
        end
        RST = 1'b0;
        hz.MultiCycleE = 1'b0;
        step();
        n_checks++;
        if (hz.McBusy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_busy got %b expected 0", hz.McBusy);
        end
    endtask

    task automatic test_forward_execute();
        clear_inputs();
        hz.WriteRegM = 5'd8; hz.RegWriteM = 1'b1;
        hz.WriteRegW = 5'd8; hz.RegWriteW = 1'b1;
        hz.RsE = 5'd8; hz.RtE = 5'd3;
        #1;
        n_checks++;
        if (hz.ForwardAE !== 2'b10) begin
            n_fail++; $display("FAIL fwd_ae_mem got %b expected 10", hz.ForwardAE);
        end
        n_checks++;
        if (hz.ForwardBE !== 2'b00) begin
            n_fail++; $display("FAIL fwd_be_none got %b expected 00", hz.ForwardBE);
        end
        hz.RegWriteM = 1'b0;
        hz.RtE = 5'd8;
        #1;
        n_checks++;
        if (hz.ForwardAE !== 2'b01) begin
            n_fail++; $display("FAIL fwd_ae_wb got %b expected 01", hz.ForwardAE);
        end
        n_checks++;
        if (hz.ForwardBE !== 2'b01) begin
            n_fail++; $display("FAIL fwd_be_wb got %b expected 01", hz.ForwardBE);
        end
        hz.RsE = 5'd0; hz.WriteRegW = 5'd0; hz.WriteRegM = 5'd0; hz.RegWriteM = 1'b1;
        #1;
        n_checks++;
        if (hz.ForwardAE !== 2'b00) begin
            n_fail++; $display("FAIL fwd_ae_r0 got %b expected 00", hz.ForwardAE);
        end
        hz.RtE = 5'd12; hz.WriteRegM = 5'd12;
        #1;
        n_checks++;
        if (hz.ForwardBE !== 2'b10) begin
            n_fail++; $display("FAIL fwd_be_mem got %b expected 10", hz.ForwardBE);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        hz.MemtoRegE = 1'b1; hz.RtE = 5'd9; hz.RsD = 5'd9; hz.RtD = 5'd4;
        #1;
        n_checks++;
        if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b111) begin
            n_fail++; $display("FAIL lw_stall got %b expected 111", {hz.StallF, hz.StallD, hz.FlushE});
        end
        step();
        hz.MemtoRegE = 1'b0;
        #1;
        n_checks++;
        if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b000) begin
            n_fail++; $display("FAIL lw_release got %b expected 000", {hz.StallF, hz.StallD, hz.FlushE});
        end
        // r0 still matches on the load-use path.
        hz.MemtoRegE = 1'b1; hz.RtE = 5'd0; hz.RsD = 5'd7; hz.RtD = 5'd0;
        #1;
        n_checks++;
        if (hz.StallF !== 1'b1) begin
            n_fail++; $display("FAIL lw_r0 got %b expected 1", hz.StallF);
        end
    endtask

    task automatic test_branch();
        clear_inputs();
        hz.BranchD = 1'b1; hz.RsD = 5'd5; hz.RtD = 5'd6;
        hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd5;
        #1;
        n_checks++;
        if ({hz.StallF, hz.FlushE} !== 2'b11) begin
            n_fail++; $display("FAIL br_stall_e got %b expected 11", {hz.StallF, hz.FlushE});
        end
        hz.RegWriteE = 1'b0; hz.WriteRegE = 5'd0;
        hz.WriteRegM = 5'd5; hz.RegWriteM = 1'b1; hz.MemtoRegM = 1'b0;
        #1;
        n_checks++;
        if (hz.StallD !== 1'b0) begin
            n_fail++; $display("FAIL br_release got %b expected 0", hz.StallD);
        end
        n_checks++;
        if ({hz.ForwardAD, hz.ForwardBD} !== 2'b10) begin
            n_fail++; $display("FAIL br_fwd got %b expected 10", {hz.ForwardAD, hz.ForwardBD});
        end
        hz.MemtoRegM = 1'b1; hz.WriteRegM = 5'd6;
        #1;
        n_checks++;
        if ({hz.StallD, hz.ForwardBD} !== 2'b11) begin
            n_fail++; $display("FAIL br_load_m got %b expected 11", {hz.StallD, hz.ForwardBD});
        end
    endtask

    task automatic test_multicycle();
        clear_inputs();
        hz.UsesHiLoD = 1'b1;
        hz.MultiCycleE = 1'b1;
        #1;
        n_checks++;
        if (hz.StallF !== 1'b0) begin
            n_fail++; $display("FAIL mc_cycle0_stall got %b expected 0", hz.StallF);
        end
        step();
        hz.MultiCycleE = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            n_checks++;
            if (hz.McBusy !== 1'(c <= 4)) begin
                n_fail++; $display("FAIL mc_busy_c%0d got %b expected %b", c, hz.McBusy, 1'(c <= 4));
            end
            n_checks++;
            if (hz.McDone !== 1'(c == 4)) begin
                n_fail++; $display("FAIL mc_done_c%0d got %b expected %b", c, hz.McDone, 1'(c == 4));
            end
            n_checks++;
            if (hz.StallD !== 1'(c <= 4)) begin
                n_fail++; $display("FAIL mc_stall_c%0d got %b expected %b", c, hz.StallD, 1'(c <= 4));
            end
            step();
        end
    endtask

    task automatic test_overlap();
        clear_inputs();
        hz.MultiCycleE = 1'b1;
        step();
        hz.MultiCycleE = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            n_checks++;
            if (hz.McOverlap !== 1'(c >= 3)) begin
                n_fail++; $display("FAIL ovl_flag_c%0d got %b expected %b", c, hz.McOverlap, 1'(c >= 3));
            end
            n_checks++;
            if (hz.McBusy !== 1'(c <= 4)) begin
                n_fail++; $display("FAIL ovl_busy_c%0d got %b expected %b", c, hz.McBusy, 1'(c <= 4));
            end
            hz.MultiCycleE = (c == 2);
            step();
        end
        hz.MultiCycleE = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        n_checks++;
        if (hz.McOverlap !== 1'b0) begin
            n_fail++; $display("FAIL ovl_cleared got %b expected 0", hz.McOverlap);
        end
    endtask

    task automatic test_reset_midop();
        clear_inputs();
        hz.UsesHiLoD = 1'b1;
        hz.MultiCycleE = 1'b1;
        step();
        hz.MultiCycleE = 1'b0;
        step();
        RST = 1'b1;
        #1;
        n_checks++;
        if ({hz.McBusy, hz.StallF} !== 2'b11) begin
            n_fail++; $display("FAIL rst_mid_c2 got %b expected 11", {hz.McBusy, hz.StallF});
        end
        step();
        RST = 1'b0;
        n_checks++;
        if (dut.r_mc_cnt !== 3'd0) begin
            n_fail++; $display("FAIL rst_mid_cnt got %0d expected 0", dut.r_mc_cnt);
        end
        for (int c = 3; c <= 6; c++) begin
            n_checks++;
            if ({hz.McBusy, hz.McDone, hz.StallF} !== 3'b000) begin
                n_fail++; $display("FAIL rst_mid_c%0d got %b expected 000", c, {hz.McBusy, hz.McDone, hz.StallF});
            end
            step();
        end
    endtask

    task automatic test_latency_one();
        hz1.MultiCycleE = 1'b1;
        hz1.UsesHiLoD = 1'b1;
        step();
        hz1.MultiCycleE = 1'b0;
        n_checks++;
        if ({hz1.McBusy, hz1.McDone, hz1.StallF} !== 3'b111) begin
            n_fail++; $display("FAIL lat1_c1 got %b expected 111", {hz1.McBusy, hz1.McDone, hz1.StallF});
        end
        step();
        n_checks++;
        if ({hz1.McBusy, hz1.McDone, hz1.StallF} !== 3'b000) begin
            n_fail++; $display("FAIL lat1_c2 got %b expected 000", {hz1.McBusy, hz1.McDone, hz1.StallF});
        end
    endtask

    initial begin
        hz1.RsD = '0; hz1.RtD = '0; hz1.BranchD = 1'b0; hz1.UsesHiLoD = 1'b0; hz1.MultiCycleD = 1'b0;
        hz1.RsE = '0; hz1.RtE = '0; hz1.WriteRegE = '0; hz1.RegWriteE = 1'b0; hz1.MemtoRegE = 1'b0;
        hz1.MultiCycleE = 1'b0; hz1.WriteRegM = '0; hz1.RegWriteM = 1'b0; hz1.MemtoRegM = 1'b0;
        hz1.WriteRegW = '0; hz1.RegWriteW = 1'b0;
        test_reset();
        test_forward_execute();
        test_load_use();
        test_branch();
        test_multicycle();
        test_overlap();
        test_reset_midop();
        test_latency_one();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Pipeline interlock and forwarding controller for the 5-stage MIPS core.
- Sits beside the Decode-to-Execute register and is its control source: FlushE drives that register's CLR; StallF/StallD freeze the PC and the Fetch-to-Decode register.
- Adds a sequential scoreboard for one in-flight multi-cycle operation (mul/div writing HI/LO). Decode instructions that read or start such an operation are held until it completes.

Parameters:
- REG_ADDR_WIDTH, 5: register-file address width.
- MC_LATENCY, 4: cycles the multi-cycle unit is busy after issue; legal range 1..2^CNT_WIDTH.
- CNT_WIDTH, 3: width of the busy counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- RsD, RtD  input  REG_ADDR_WIDTH  source registers of the instruction in Decode.
- BranchD  input  1  Decode holds a branch resolved in Decode.
- UsesHiLoD  input  1  Decode instruction reads the multi-cycle result.
- MultiCycleD  input  1  Decode instruction is a multi-cycle op.
- RsE, RtE  input  REG_ADDR_WIDTH  source registers in Execute.
- WriteRegE  input  REG_ADDR_WIDTH  destination register in Execute.
- RegWriteE, MemtoRegE, MultiCycleE  input  1  Execute-stage controls.
- WriteRegM  input  REG_ADDR_WIDTH; RegWriteM, MemtoRegM  input  1  Memory-stage info.
- WriteRegW  input  REG_ADDR_WIDTH; RegWriteW  input  1  Writeback-stage info.
- StallF, StallD  output  1  hold PC and the Fetch-to-Decode register.
- FlushE  output  1  clear the Decode-to-Execute register (bubble).
- ForwardAD, ForwardBD  output  1  select the Memory-stage ALU result for branch comparator operands.
- ForwardAE, ForwardBE  output  2  Execute operand select: 00 register file, 01 Writeback result, 10 Memory ALU result.
- McBusy  output  1  multi-cycle operation in flight (registered).
- McDone  output  1  last busy cycle; result is written at the end of this cycle.
- McOverlap  output  1  sticky protocol-violation flag.

Behaviour:
- Forwarding (combinational):
  - ForwardAE = 10 if RsE != 0 && RegWriteM && RsE == WriteRegM.
  - Otherwise 01 if RsE != 0 && RegWriteW && RsE == WriteRegW.
  - Otherwise 00.
  - ForwardBE is identical using RtE. The Memory stage has priority over Writeback.
- ForwardAD = RsD != 0 && RegWriteM && RsD == WriteRegM. ForwardBD is the same using RtD.
- lwstall = MemtoRegE && (RtE == RsD || RtE == RtD). Register 0 is not excluded.
- branchstall = BranchD && one of:
  - RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)
  - MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)
- mcstall = McBusy && (UsesHiLoD || MultiCycleD).
- StallF = StallD = FlushE = lwstall | branchstall | mcstall. These are combinational, with no registered delay.
- Scoreboard (registers McBusy, McCnt[CNT_WIDTH-1:0], McOverlap):
  - Idle, with MultiCycleE = 1 at edge t: McBusy <= 1, McCnt <= MC_LATENCY-1.
  - McBusy = 1 and McCnt != 0: McCnt decrements.
  - McBusy = 1 and McCnt == 0: McBusy <= 0. McDone = McBusy && McCnt == 0 (combinational).
  - Timing: issue seen at edge t gives McBusy high for t+1 .. t+MC_LATENCY and McDone at t+MC_LATENCY. A dependent Decode instruction is released at t+MC_LATENCY+1.
  - McDone cycle: mcstall is still asserted, because the result is not yet visible in that cycle.
  - MultiCycleE = 1 while McBusy = 1 (interlock bypassed): the new issue is ignored, the count continues, and McOverlap <= 1 (sticky).
  - MC_LATENCY = 1: busy for exactly one cycle, and McDone is high in that cycle.
- Reset:
  - RST = 1 at an edge sets McBusy = 0, McCnt = 0, McOverlap = 0. Reset has priority over MultiCycleE.
  - Reset mid-operation abandons the count; McDone is not produced.
  - Combinational outputs follow the inputs during reset, with McBusy = 0.

Test Plan:
- WriteRegM = 8 with RegWriteM = 1, WriteRegW = 8 with RegWriteW = 1, RsE = 8 -> ForwardAE = 10. Drop RegWriteM -> ForwardAE = 01. RsE = 0 -> 00.
- MemtoRegE = 1, RtE = 9, RsD = 9 -> StallF = StallD = FlushE = 1 for one cycle. Next cycle MemtoRegE = 0 -> all 0.
- BranchD = 1, RsD = 5, RegWriteE = 1, WriteRegE = 5 -> stall 1. Move the producer to M with MemtoRegM = 0, RegWriteM = 1 -> stall 0, ForwardAD = 1.
- MC_LATENCY = 4, MultiCycleE pulse at edge 0, UsesHiLoD held high:
  - McBusy = 1 at cycles 1-4, McDone = 1 at cycle 4.
  - Stall asserted at cycles 1-4 and deasserted at cycle 5.
- MultiCycleE pulses at edge 0 and again at cycle 2 -> McOverlap = 1 from cycle 3 until reset; McBusy still falls at cycle 5.
- Issue at edge 0, RST = 1 at cycle 2 -> McBusy = 0 and McCnt = 0 from cycle 3, no McDone, and a UsesHiLoD stall clears at cycle 3.
